// File: rtl/present_pkg.sv
// Shared constants, types and pure helpers for the PRESENT-80 encryption core.
package present_pkg;

    localparam int ROUNDS = 31;
    localparam int KEY_W  = 80;
    localparam int BLK_W  = 64;
    localparam int RND_W  = 6;

    localparam logic [RND_W-1:0] RND_FINAL = RND_W'(ROUNDS + 1);

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {
        PH_LOAD  = 2'd0,
        PH_ROUND = 2'd1,
        PH_FINAL = 2'd2
    } phase_t;

    function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] d);
        logic [BLK_W-1:0] q;
        q = '0;
        for (int i = 0; i < 63; i++) begin
            q[6'((16 * i) % 63)] = d[i];
        end
        q[63] = d[63];
        return q;
    endfunction

    // Rotation and round-counter mix only; the top nibble S-box is a separate
    // instance in the datapath. The two touch disjoint bits, so order is free.
    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                   input logic [4:0]       rc);
        logic [KEY_W-1:0] r;
        r = {k[18:0], k[79:19]};
        r[19:15] = r[19:15] ^ rc;
        return r;
    endfunction

endpackage

// File: rtl/present_sbox.sv
// PRESENT 4-bit S-box, purely combinational.
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] subst
);

    assign subst = SBOX[nibble];

endmodule

// File: rtl/present_p.sv
// Iterative PRESENT-80 encryption core, one round per clock, reloading every 32 cycles.
// Build with P_DONE_EN to add the one-cycle `done` strobe on each new result.
//
// phase    | meaning
// PH_LOAD  | rnd==0: capture state/keys, start round 1
// PH_ROUND | rnd 1..31: one full round and key schedule step
// PH_FINAL | rnd==32: publish whitened ciphertext and reload next block
module present_p
    import present_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BLK_W-1:0] state,
    input  logic [KEY_W-1:0] keys,
    output logic [BLK_W-1:0] result
`ifdef P_DONE_EN
    ,
    output logic             done
`endif
);

    logic [BLK_W-1:0] st;
    logic [BLK_W-1:0] st_next;
    logic [KEY_W-1:0] kr;
    logic [KEY_W-1:0] kr_next;
    logic [RND_W-1:0] rnd;
    logic [RND_W-1:0] rnd_next;
    logic [BLK_W-1:0] result_next;
    phase_t           phase;

    logic [BLK_W-1:0] sb_in;
    logic [BLK_W-1:0] sb_out;
    logic [KEY_W-1:0] kr_mix;
    logic [3:0]       key_nib;
    logic [KEY_W-1:0] kr_upd;

`ifdef P_DONE_EN
    logic done_next;
`endif

    assign sb_in = st ^ kr[79:16];

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        present_sbox u_sbox (
            .nibble (sb_in[4*i +: 4]),
            .subst  (sb_out[4*i +: 4])
        );
    end

    assign kr_mix = key_update(kr, rnd[4:0]);

    present_sbox u_key_sbox (
        .nibble (kr_mix[79:76]),
        .subst  (key_nib)
    );

    assign kr_upd = {key_nib, kr_mix[75:0]};

    // Out-of-range counts can only come from upset; fold them into a reload.
    assign phase = (rnd == '0 || rnd > RND_FINAL) ? PH_LOAD  :
                   (rnd == RND_FINAL)             ? PH_FINAL :
                                                    PH_ROUND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= '0;
            kr     <= '0;
            rnd    <= '0;
            result <= '0;
`ifdef P_DONE_EN
            done   <= 1'b0;
`endif
        end else begin
            st     <= st_next;
            kr     <= kr_next;
            rnd    <= rnd_next;
            result <= result_next;
`ifdef P_DONE_EN
            done   <= done_next;
`endif
        end
    end

    always_comb begin
        st_next  = st;
        kr_next  = kr;
        rnd_next = rnd;
        case (phase)
            PH_LOAD, PH_FINAL: begin
                st_next  = state;
                kr_next  = keys;
                rnd_next = RND_W'(1);
            end
            default: begin
                st_next  = p_layer(sb_out);
                kr_next  = kr_upd;
                rnd_next = rnd + RND_W'(1);
            end
        endcase
    end

    always_comb begin
        result_next = result;
        if (phase == PH_FINAL) begin
            result_next = st ^ kr[79:16];
        end
`ifdef P_DONE_EN
        done_next = (phase == PH_FINAL);
`endif
    end

endmodule

// File: tb/tb_present_p.sv
// Scoreboard bench for present_p: known-answer PRESENT-80 blocks, mid-block input
// changes, back-to-back repeats and a mid-block reset. Checks `done` when P_DONE_EN is set.
module tb_present_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] state;
    logic [79:0] keys;
    logic [63:0] result;
`ifdef P_DONE_EN
    logic        done;
`endif

    int          checks = 0;
    int          errors = 0;
    int          edge_cnt;
    logic [63:0] exp_q[$];
    logic [63:0] held = 64'h0;

    logic [63:0] vs [7];
    logic [79:0] vk [7];
    logic [63:0] ve [7];

    localparam logic [63:0] S1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] K1 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    present_p dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .state  (state),
        .keys   (keys),
`ifdef P_DONE_EN
        .done   (done),
`endif
        .result (result)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t edge %0d: got %h want %h", name, $time, edge_cnt, act, req);
        end
    endtask

    // Monitor: result must only change on the 33rd edge after release and every 32 after.
    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ev = (edge_cnt >= 33) && (((edge_cnt - 33) % 32) == 0);
                if (ev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result at edge %0d: got %h want none", edge_cnt, result);
                    end else begin
                        held = exp_q.pop_front();
                        check64("result", result, held);
                    end
                end else begin
                    check64("result_hold", result, held);
                end
`ifdef P_DONE_EN
                check64("done", 64'(done), 64'(ev));
`endif
            end else begin
                held = 64'h0;
            end
        end
    end

    initial begin
        vs[0] = 64'h0; vk[0] = 80'h0; ve[0] = 64'h5579C1387B228445;
        vs[1] = 64'h0; vk[1] = K1;    ve[1] = 64'hE72C46C0F5945049;
        vs[2] = S1;    vk[2] = 80'h0; ve[2] = 64'hA112FFC72F68417B;
        vs[3] = S1;    vk[3] = K1;    ve[3] = 64'h3333DCD3213210D2;
        vs[4] = S1;    vk[4] = K1;    ve[4] = 64'h3333DCD3213210D2;
        vs[5] = S1;    vk[5] = 80'h0; ve[5] = 64'hA112FFC72F68417B;
        vs[6] = 64'h0; vk[6] = 80'h0; ve[6] = 64'h5579C1387B228445;

        state = vs[0];
        keys  = vk[0];
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_result", result, 64'h0);
`ifdef P_DONE_EN
        check64("reset_done", 64'(done), 64'h0);
`endif
        exp_q.push_back(ve[0]);
        #1 rst_n = 1'b1;

        // Next block's inputs change on edge 10 of the current block.
        for (int b = 1; b < 7; b++) begin
            while (edge_cnt != 32 * b - 22) @(negedge clk);
            state = vs[b];
            keys  = vk[b];
            exp_q.push_back(ve[b]);
        end

        // Abort block 7 on its 20th edge.
        while (edge_cnt != 243) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check64("abort_result", result, 64'h0);
`ifdef P_DONE_EN
        check64("abort_done", 64'(done), 64'h0);
`endif
        state = S1;
        keys  = K1;
        exp_q.push_back(64'h3333DCD3213210D2);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results want 0", exp_q.size());
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
